uart_rx_byte: RTL and testbench

Serial receive front end for the UART matrix-vector-multiply design. Recovers 8N1 frames from the `ui_in[0]` serial pin and hands completed bytes to the MVM command/operand loader over a valid/ready interface. It sits directly upstream of the MVM core inside `tt_um_uart_mvm`. It reports framing errors and overruns as single-cycle pulses for the status outputs.

---
 rtl/uart_rx_byte.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver with a one-deep valid/ready output register.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge
    // S_START  | counting to the middle of the start bit
    // S_DATA   | sampling eight data bits, LSB first
    // S_PARITY | sampling the even-parity bit (parity build only)
    // S_STOP   | sampling the stop bit, completing or rejecting the byte
    // S_BREAK  | stop bit was low, waiting for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync_1;
    logic          r_sync_2;
    logic          r_rx_prev;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shift_nx;
    logic          w_rx_s;
    logic          w_fall;
    logic          w_tick;
    logic          w_done;
    logic          w_ferr;

`ifdef UART_RX_PARITY_EN
    logic          r_par;
    logic          w_par_nx;
    logic          w_par_ok;
`endif

    assign w_rx_s = r_sync_2;
    assign w_fall = r_rx_prev & ~w_rx_s;
    assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
    assign w_par_ok = ~(^{r_shift, r_par});
`endif

    // Synchronizer and edge-detect history idle high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_1  <= 1'b1;
            r_sync_2  <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync_1  <= rx_i;
            r_sync_2  <= r_sync_1;
            r_rx_prev <= r_sync_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_done     = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nx = S_START;
                    w_cnt_nx   = C_HALF;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_state_nx = S_DATA;
                        w_cnt_nx   = C_FULL;
                        w_bit_nx   = '0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nx = {w_rx_s, r_shift[7:1]};
                    w_cnt_nx   = C_FULL;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_par_nx   = w_rx_s;
                    w_cnt_nx   = C_FULL;
                    w_state_nx = S_STOP;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
`ifdef UART_RX_PARITY_EN
                    // A parity mismatch rejects the byte even when the stop bit is good.
                    w_done = w_par_ok & w_rx_s;
                    w_ferr = ~w_par_ok | ~w_rx_s;
`else
                    w_done = w_rx_s;
                    w_ferr = ~w_rx_s;
`endif
                    w_state_nx = w_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A completing byte may replace the held one only when that one leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_ferr;
            overrun   <= 1'b0;
            if (w_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte; honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_byte;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAST_SLOT = 10;
    localparam int NBITS     = 11;
`else
    localparam int LAST_SLOT = 9;
    localparam int NBITS     = 10;
`endif
    // Edge (counted from the edge before the start bit is driven) at which outputs update.
    localparam int DONE_EDGE = H + LAST_SLOT * N + 3;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ferr   = 0;
    int   n_ovr    = 0;
    int   n_vrise  = 0;
    logic v_prev   = 1'b0;
    int   s_ferr;
    int   s_ovr;
    int   s_vrise;

    uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (rx_valid && !v_prev) n_vrise++;
        v_prev = rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_ferr  = n_ferr;
        s_ovr   = n_ovr;
        s_vrise = n_vrise;
    endtask

    // Called just after a clock edge; returns just after a clock edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, (^d) ^ par_bad, d, 1'b0};
`else
        bits = {par_bad, stop_b, d, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++) begin
            rx_i = bits[i];
            repeat (N) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    endtask

    task automatic accept(input string tag);
        check_eq({tag, "_pre_valid"}, {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check_eq({tag, "_post_valid"}, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_i     = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_data", {24'd0, rx_data}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_ovr", {31'd0, overrun}, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // single byte with exact completion timing
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (DONE_EDGE - 1) @(posedge clk);
                #2;
                check_eq("a5_early_valid", {31'd0, rx_valid}, 32'd0);
                @(posedge clk);
                #2;
                check_byte("a5_ontime", 8'hA5);
                check_eq("a5_ferr", {31'd0, frame_err}, 32'd0);
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check_byte("a5_hold", 8'hA5);
        accept("a5_acc");

        // glitch rejection
        snap();
        rx_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (3 * N) @(posedge clk);
        #1;
        check_eq("glitch_vrise", n_vrise - s_vrise, 0);
        check_eq("glitch_ferr", n_ferr - s_ferr, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_byte("3c", 8'h3C);
        accept("3c_acc");

        // framing error and break
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (30 * N) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (2 * N) @(posedge clk);
        #1;
        check_eq("brk_ferr", n_ferr - s_ferr, 1);
        check_eq("brk_vrise", n_vrise - s_vrise, 0);
        check_eq("brk_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check_byte("0f", 8'h0F);
        check_eq("0f_ferr", n_ferr - s_ferr, 1);
        accept("0f_acc");

        // overrun
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_eq("ovr_cnt", n_ovr - s_ovr, 1);
        check_eq("ovr_vrise", n_vrise - s_vrise, 1);
        check_byte("ovr_keep", 8'h11);
        accept("ovr_acc");

        // accept in the completion cycle of the second byte
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                repeat (DONE_EDGE - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        check_eq("simul_ovr", n_ovr - s_ovr, 0);
        check_byte("simul", 8'h22);
        accept("simul_acc");

        // reset during data bit 4
        snap();
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (5 * N + 4) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        repeat (N) @(posedge clk);
        #1;
        check_eq("mrst_vrise", n_vrise - s_vrise, 0);
        check_eq("mrst_ferr", n_ferr - s_ferr, 0);
        check_eq("mrst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("mrst_data", {24'd0, rx_data}, 32'd0);
        check_eq("mrst_ovr", {31'd0, overrun}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        check_byte("81", 8'h81);
        accept("81_acc");

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h03, 1'b1, 1'b0);
        check_byte("par_ok", 8'h03);
        check_eq("par_ok_ferr", n_ferr - s_ferr, 0);
        accept("par_ok_acc");
        snap();
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (N) @(posedge clk);
        #1;
        check_eq("par_bad_ferr", n_ferr - s_ferr, 1);
        check_eq("par_bad_vrise", n_vrise - s_vrise, 0);
        check_eq("par_bad_valid", {31'd0, rx_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
